sum_accum_4: RTL



---
 rtl/sum_accum_4_if.sv | 24 ++
 rtl/sum_accum_4.sv | 102 ++++++++++
 2 files changed

// File: rtl/sum_accum_4_if.sv
// rtl/sum_accum_4_if.sv - beat input / block total output handshake bundle for sum_accum_4
interface sum_accum_4_if #(
  parameter int ACC_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sum;
  logic             in_c;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  modport master (
    output clear, in_valid, in_sum, in_c, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  clear, in_valid, in_sum, in_c, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/sum_accum_4.sv
// rtl/sum_accum_4.sv - accumulates LEN adder results into a block total with sticky overflow
// SUM_ACCUM_SATURATE_EN: clamp the accumulator at all-ones on overflow instead of wrapping.
module sum_accum_4 #(
  parameter int LEN   = 8,
  parameter int ACC_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sum_accum_4_if.slave bus
);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] acc_out_r;
  logic [CNT_W-1:0] cnt;
  logic             sticky;
  logic             sticky_next;
  logic             ovf_r;
  logic [ACC_W:0]   sum_wide;
  logic             in_fire;
  logic             out_fire;
  logic             last_beat;

  // One extra bit catches the carry out of the accumulator MSB.
  assign sum_wide = {1'b0, acc} + {{(ACC_W-4){1'b0}}, bus.in_c, bus.in_sum};

  assign bus.acc_out = acc_out_r;
  assign bus.ovf     = ovf_r;

  always_comb begin
    state_next    = state;
    acc_next      = acc;
    sticky_next   = sticky;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    in_fire       = 1'b0;
    out_fire      = 1'b0;
    last_beat     = 1'b0;
    case (state)
      ACCUM: begin
        bus.in_ready = 1'b1;
        in_fire      = bus.in_valid;
        last_beat    = in_fire && (cnt == CNT_W'(LEN - 1));
        if (in_fire) begin
          sticky_next = sticky | sum_wide[ACC_W];
`ifdef SUM_ACCUM_SATURATE_EN
          acc_next = sticky_next ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
          acc_next = sum_wide[ACC_W-1:0];
`endif
        end
        if (last_beat) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        out_fire      = bus.out_ready;
        if (out_fire) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Reset and clear share one path; reset simply wins by being checked in the same term.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      acc_out_r <= '0;
      ovf_r     <= 1'b0;
    end else begin
      state <= state_next;
      if (in_fire) begin
        acc    <= acc_next;
        sticky <= sticky_next;
        cnt    <= last_beat ? '0 : cnt + 1'b1;
      end
      if (last_beat) begin
        acc_out_r <= acc_next;
        ovf_r     <= sticky_next;
      end
      if (out_fire) begin
        acc    <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end
    end
  end
endmodule
